// File: rtl/timer_bank_if.sv
// -----------------------------------------------------------------------------
// timer_bank_if
// Groups the CPU bus signals that reach the timer bank.
// The CPU side (address decode plus Z80 strobes) is the master; the timer bank
// is the slave and returns combinational read data.
//   cs    : block select from the address decoder
//   rd_n  : read strobe, active low, held as a level
//   wr_n  : write strobe, active low, held as a level
//   addr  : {channel, offset[3:0]}
//   din   : CPU write data
//   dout  : read data, forced to zero outside an active read
// -----------------------------------------------------------------------------
interface timer_bank_if #(
    parameter int ADDR_W = 6
);
    logic              cs;
    logic              rd_n;
    logic              wr_n;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        dout;

    modport master (
        output cs,
        output rd_n,
        output wr_n,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  cs,
        input  rd_n,
        input  wr_n,
        input  addr,
        input  din,
        output dout
    );
endinterface

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
// Bank of CPU-visible timers with prescaler, compare match, auto-reload,
// overflow flags, tear-free multi-byte count reads and a level interrupt.
//
// Parameters
//   CHANNELS : number of timer channels (1..8)
//   WIDTH    : counter / compare width in bits (8, 16, 24 or 32)
//   PRESCALE : clk_sys cycles per tick (>= 2)
//   RESET_EN : reset value of CTRL.EN, bit i belongs to channel i
//
// Ports
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset
//   bus     : CPU bus (slave side), addr = {channel, offset[3:0]}
//   int_n   : registered level interrupt, active low
//
// Per-channel register map (16 byte stride)
//   0..3  COUNT   (write any byte clears count and prescaler)
//   4..7  COMPARE
//   8     CTRL    [0]EN [1]RELOAD [2]MIE [3]OIE
//   9     STATUS  [0]MATCH [1]OVF, write-1-to-clear
//   Bytes beyond WIDTH/8 and offsets 10..15 read 0 and ignore writes.
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int         CHANNELS = 4,
    parameter int         WIDTH    = 16,
    parameter int         PRESCALE = 24000,
    parameter logic [7:0] RESET_EN = 8'b1
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    timer_bank_if.slave  bus,
    output logic         int_n
);

    localparam int              CH_BITS    = $clog2(CHANNELS);
    localparam int              NBYTES     = WIDTH / 8;
    localparam int              PW         = $clog2(PRESCALE);
    localparam logic [3:0]      NBYTES4    = 4'(NBYTES);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    // Bus decode
    logic                bus_rd;
    logic                bus_wr;
    logic [3:0]          off;
    logic [CHANNELS-1:0] ch_sel;

    // Per-channel state
    logic [WIDTH-1:0] count_q   [CHANNELS];
    logic [WIDTH-1:0] count_d   [CHANNELS];
    logic [WIDTH-1:0] compare_q [CHANNELS];
    logic [WIDTH-1:0] compare_d [CHANNELS];
    logic [WIDTH-1:0] snap_q    [CHANNELS];
    logic [WIDTH-1:0] snap_d    [CHANNELS];
    logic [PW-1:0]    presc_q   [CHANNELS];
    logic [PW-1:0]    presc_d   [CHANNELS];
    logic [3:0]       ctrl_q    [CHANNELS];
    logic [3:0]       ctrl_d    [CHANNELS];
    logic [1:0]       status_q  [CHANNELS];
    logic [1:0]       status_d  [CHANNELS];

    // Per-channel helpers
    logic [CHANNELS-1:0] tick;
    logic [1:0]          hw_set [CHANNELS];
    logic [CHANNELS-1:0] count_wr;

    // Interrupt
    logic irq_any;
    logic int_n_d;
    logic int_n_q;

    assign bus_rd = bus.cs & ~bus.rd_n;
    assign bus_wr = bus.cs & ~bus.wr_n;
    assign off    = bus.addr[3:0];

    // Channel select is one-hot; an address whose channel field is at or
    // beyond CHANNELS selects nothing, so it reads 0 and writes are dropped.
    generate
        if (CH_BITS == 0) begin : g_single_channel
            assign ch_sel = 1'b1;
        end else begin : g_multi_channel
            always_comb begin
                for (int i = 0; i < CHANNELS; i++) begin
                    ch_sel[i] = (bus.addr[CH_BITS+3:4] == CH_BITS'(i));
                end
            end
        end
    endgenerate

    // Next-state logic for every channel. Order matters: the tick result is
    // computed first and then overridden by a COUNT write, and STATUS
    // write-1-to-clear is applied before the hardware set bits are OR-ed in,
    // so a flag raised in the same cycle survives the clear.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i]   = count_q[i];
            compare_d[i] = compare_q[i];
            snap_d[i]    = snap_q[i];
            presc_d[i]   = presc_q[i];
            ctrl_d[i]    = ctrl_q[i];
            status_d[i]  = status_q[i];
            hw_set[i]    = 2'b00;

            tick[i]     = ctrl_q[i][0] && (presc_q[i] == PRESC_LAST);
            count_wr[i] = bus_wr && ch_sel[i] && (off < NBYTES4);

            if (ctrl_q[i][0]) begin
                presc_d[i] = tick[i] ? '0 : presc_q[i] + PW'(1);
            end

            if (tick[i]) begin
                if (count_q[i] == compare_q[i]) begin
                    hw_set[i][0] = 1'b1;
                    count_d[i]   = ctrl_q[i][1] ? '0 : count_q[i] + WIDTH'(1);
                end else if (count_q[i] == COUNT_MAX) begin
                    hw_set[i][1] = 1'b1;
                    count_d[i]   = '0;
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end

            // Restarting the count also restarts the prescaler so the next
            // tick arrives a full PRESCALE period after the write.
            if (count_wr[i]) begin
                count_d[i] = '0;
                presc_d[i] = '0;
            end

            if (bus_wr && ch_sel[i]) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (off == 4'(4 + b)) begin
                        compare_d[i][8*b +: 8] = bus.din;
                    end
                end
                if (off == 4'd8) begin
                    ctrl_d[i] = bus.din[3:0];
                end
                if (off == 4'd9) begin
                    status_d[i] = status_q[i] & ~bus.din[1:0];
                end
            end

            status_d[i] = status_d[i] | hw_set[i];

            // Reading the LSB captures the whole count, so the upper bytes
            // read afterwards belong to the same value even if a tick lands
            // between the CPU byte reads.
            if (bus_rd && ch_sel[i] && (off == 4'd0)) begin
                snap_d[i] = count_q[i];
            end
        end
    end

    // Interrupt request is the OR of every enabled flag; registered to give a
    // clean level for the CPU int_n pin.
    always_comb begin
        irq_any = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            irq_any = irq_any
                    | (status_q[i][0] & ctrl_q[i][2])
                    | (status_q[i][1] & ctrl_q[i][3]);
        end
        int_n_d = ~irq_any;
    end

    // Combinational read mux. Offset 0 is the live LSB; offsets 1..3 come
    // from the snapshot taken on the last LSB read.
    always_comb begin
        bus.dout = 8'h00;
        if (bus_rd) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_sel[i]) begin
                    if (off == 4'd0) begin
                        bus.dout = count_q[i][7:0];
                    end
                    for (int b = 1; b < NBYTES; b++) begin
                        if (off == 4'(b)) begin
                            bus.dout = snap_q[i][8*b +: 8];
                        end
                    end
                    for (int b = 0; b < NBYTES; b++) begin
                        if (off == 4'(4 + b)) begin
                            bus.dout = compare_q[i][8*b +: 8];
                        end
                    end
                    if (off == 4'd8) begin
                        bus.dout = {4'b0000, ctrl_q[i]};
                    end
                    if (off == 4'd9) begin
                        bus.dout = {6'b000000, status_q[i]};
                    end
                end
            end
        end
    end

    // State registers; reset clears everything at once, including any
    // partly counted prescaler period.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]   <= '0;
                compare_q[i] <= '0;
                snap_q[i]    <= '0;
                presc_q[i]   <= '0;
                ctrl_q[i]    <= {3'b000, RESET_EN[i]};
                status_q[i]  <= 2'b00;
            end
            int_n_q <= 1'b1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]   <= count_d[i];
                compare_q[i] <= compare_d[i];
                snap_q[i]    <= snap_d[i];
                presc_q[i]   <= presc_d[i];
                ctrl_q[i]    <= ctrl_d[i];
                status_q[i]  <= status_d[i];
            end
            int_n_q <= int_n_d;
        end
    end

    assign int_n = int_n_q;

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
// Two timer banks side by side: dut_a (4 channels, 16 bit) and dut_b
// (3 channels, 8 bit), both with PRESCALE = 4. Stimulus pushes the expected
// byte into a queue whenever it asks the DUT for an output; the monitor pops
// and compares on the falling clock edge while that output is presented.
// -----------------------------------------------------------------------------
module tb_timer_bank;

    localparam int KIND_DOUT_A = 1;
    localparam int KIND_DOUT_B = 2;
    localparam int KIND_INT_A  = 3;
    localparam int KIND_INT_B  = 4;

    logic clk_sys = 1'b0;
    logic reset_n;
    logic int_a;
    logic int_b;

    timer_bank_if #(.ADDR_W(6)) bus_a ();
    timer_bank_if #(.ADDR_W(6)) bus_b ();

    timer_bank #(
        .CHANNELS (4),
        .WIDTH    (16),
        .PRESCALE (4),
        .RESET_EN (8'b0000_0001)
    ) dut_a (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus_a),
        .int_n   (int_a)
    );

    timer_bank #(
        .CHANNELS (3),
        .WIDTH    (8),
        .PRESCALE (4),
        .RESET_EN (8'b0000_0001)
    ) dut_b (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus_b),
        .int_n   (int_b)
    );

    always #5 clk_sys = ~clk_sys;

    int          checks     = 0;
    int          errors     = 0;
    int          probe_kind = 0;
    logic [7:0]  exp_q  [$];
    int          kind_q [$];
    string       name_q [$];

    // Bus drive helpers
    task automatic driveBus(input bit use_b, input logic cs, input logic rd_n,
                            input logic wr_n, input logic [5:0] a, input logic [7:0] d);
        if (use_b) begin
            bus_b.cs = cs; bus_b.rd_n = rd_n; bus_b.wr_n = wr_n; bus_b.addr = a; bus_b.din = d;
        end else begin
            bus_a.cs = cs; bus_a.rd_n = rd_n; bus_a.wr_n = wr_n; bus_a.addr = a; bus_a.din = d;
        end
    endtask

    task automatic idleBus();
        driveBus(1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 8'h00);
        driveBus(1'b1, 1'b0, 1'b1, 1'b1, 6'h00, 8'h00);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // One-cycle write, sampled on exactly one rising edge.
    task automatic applyStimulus(input bit use_b, input logic [5:0] a, input logic [7:0] d);
        driveBus(use_b, 1'b1, 1'b1, 1'b0, a, d);
        @(posedge clk_sys);
        #1;
        idleBus();
    endtask

    // Presents one output for a cycle and queues what it must be. For dout
    // kinds the bus is selected; strobe=0 keeps rd_n high.
    task automatic checkOutput(input int kind, input logic [5:0] a, input logic [7:0] expv,
                               input bit strobe, input string nm);
        exp_q.push_back(expv);
        kind_q.push_back(kind);
        name_q.push_back(nm);
        if (kind == KIND_DOUT_A) driveBus(1'b0, 1'b1, !strobe, 1'b1, a, 8'h00);
        if (kind == KIND_DOUT_B) driveBus(1'b1, 1'b1, !strobe, 1'b1, a, 8'h00);
        probe_kind = kind;
        @(posedge clk_sys);
        #1;
        probe_kind = 0;
        idleBus();
    endtask

    // Monitor / scoreboard
    initial begin
        logic [7:0] actual;
        logic [7:0] expv;
        int         k;
        string      nm;
        forever begin
            @(negedge clk_sys);
            if (probe_kind != 0) begin
                checks++;
                case (probe_kind)
                    KIND_DOUT_A: actual = bus_a.dout;
                    KIND_DOUT_B: actual = bus_b.dout;
                    KIND_INT_A:  actual = {7'b0, int_a};
                    default:     actual = {7'b0, int_b};
                endcase
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard: output kind %0d presented, got %02h, nothing expected",
                             probe_kind, actual);
                end else begin
                    expv = exp_q.pop_front();
                    k    = kind_q.pop_front();
                    nm   = name_q.pop_front();
                    if (k != probe_kind || actual !== expv) begin
                        errors++;
                        $display("[TB] FAIL %s: got %02h (kind %0d), expected %02h (kind %0d)",
                                 nm, actual, probe_kind, expv, k);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        probe_kind = 0;
        idleBus();
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;

        // 1: reset state, ch0 free-runs from RESET_EN
        $display("[TB] reset and free-running channel 0");
        step(40);
        checkOutput(KIND_DOUT_A, 6'h00, 8'd10, 1'b1, "t1 ch0 count after 40 cycles");
        checkOutput(KIND_DOUT_A, 6'h10, 8'h00, 1'b1, "t1 ch1 count disabled");
        checkOutput(KIND_INT_A,  6'h00, 8'h01, 1'b0, "t1 int_n idle");
        checkOutput(KIND_DOUT_A, 6'h08, 8'h01, 1'b1, "t1 ch0 ctrl reset");
        checkOutput(KIND_DOUT_A, 6'h18, 8'h00, 1'b1, "t1 ch1 ctrl reset");
        checkOutput(KIND_DOUT_A, 6'h08, 8'h00, 1'b0, "t1 dout zero with rd_n high");
        checkOutput(KIND_DOUT_A, 6'h0A, 8'h00, 1'b1, "t1 offset 10 reads zero");
        checkOutput(KIND_DOUT_A, 6'h02, 8'h00, 1'b1, "t1 byte beyond width reads zero");
        applyStimulus(1'b1, 6'h38, 8'h0F);
        checkOutput(KIND_DOUT_B, 6'h38, 8'h00, 1'b1, "t1 unused channel reads zero");

        // 2: ch1 compare 3 with reload and MIE
        $display("[TB] compare match with reload");
        applyStimulus(1'b0, 6'h14, 8'h03);
        applyStimulus(1'b0, 6'h18, 8'h07);
        applyStimulus(1'b0, 6'h10, 8'h00);
        step(4);
        checkOutput(KIND_DOUT_A, 6'h10, 8'd1, 1'b1, "t2 count tick1");
        step(3);
        checkOutput(KIND_DOUT_A, 6'h10, 8'd2, 1'b1, "t2 count tick2");
        step(3);
        checkOutput(KIND_DOUT_A, 6'h10, 8'd3, 1'b1, "t2 count tick3");
        step(2);
        checkOutput(KIND_INT_A,  6'h00, 8'h01, 1'b0, "t2 int_n before match");
        checkOutput(KIND_DOUT_A, 6'h19, 8'h01, 1'b1, "t2 status match set");
        checkOutput(KIND_INT_A,  6'h00, 8'h00, 1'b0, "t2 int_n low after match");
        checkOutput(KIND_DOUT_A, 6'h10, 8'd0, 1'b1, "t2 count reloaded");
        applyStimulus(1'b0, 6'h19, 8'h01);
        checkOutput(KIND_INT_A,  6'h00, 8'h00, 1'b0, "t2 int_n same cycle as clear");
        checkOutput(KIND_INT_A,  6'h00, 8'h01, 1'b0, "t2 int_n released");
        checkOutput(KIND_DOUT_A, 6'h19, 8'h00, 1'b1, "t2 status cleared");
        checkOutput(KIND_DOUT_A, 6'h10, 8'd1, 1'b1, "t2 count after reload");

        // 4: tear-free read across 0x00FF -> 0x0100
        $display("[TB] snapshot read");
        applyStimulus(1'b0, 6'h28, 8'h01);
        applyStimulus(1'b0, 6'h20, 8'h00);
        step(1023);
        checkOutput(KIND_DOUT_A, 6'h20, 8'hFF, 1'b1, "t4 live lsb 0xff");
        checkOutput(KIND_DOUT_A, 6'h21, 8'h00, 1'b1, "t4 snapshot msb old");
        checkOutput(KIND_DOUT_A, 6'h20, 8'h00, 1'b1, "t4 live lsb 0x00");
        checkOutput(KIND_DOUT_A, 6'h21, 8'h01, 1'b1, "t4 snapshot msb new");

        // 3: 8-bit overflow on dut_b ch2
        $display("[TB] overflow");
        applyStimulus(1'b1, 6'h24, 8'h80);
        applyStimulus(1'b1, 6'h28, 8'h09);
        applyStimulus(1'b1, 6'h20, 8'h00);
        step(1022);
        checkOutput(KIND_DOUT_B, 6'h20, 8'hFF, 1'b1, "t3 count at max");
        checkOutput(KIND_INT_B,  6'h00, 8'h01, 1'b0, "t3 int_n before overflow");
        checkOutput(KIND_DOUT_B, 6'h20, 8'h00, 1'b1, "t3 count wrapped");
        checkOutput(KIND_INT_B,  6'h00, 8'h00, 1'b0, "t3 int_n overflow");
        checkOutput(KIND_DOUT_B, 6'h29, 8'h03, 1'b1, "t3 status match and ovf");
        applyStimulus(1'b1, 6'h29, 8'h01);
        checkOutput(KIND_DOUT_B, 6'h29, 8'h02, 1'b1, "t3 ovf kept after match clear");
        checkOutput(KIND_INT_B,  6'h00, 8'h00, 1'b0, "t3 int_n still low");

        // 5: COUNT write priority and prescaler restart on dut_a ch3
        $display("[TB] count write priority");
        applyStimulus(1'b0, 6'h38, 8'h01);
        applyStimulus(1'b0, 6'h30, 8'h00);
        step(11);
        applyStimulus(1'b0, 6'h30, 8'hAA);
        checkOutput(KIND_DOUT_A, 6'h30, 8'd0, 1'b1, "t5 write beats tick");
        step(2);
        checkOutput(KIND_DOUT_A, 6'h30, 8'd0, 1'b1, "t5 no tick before period");
        checkOutput(KIND_DOUT_A, 6'h30, 8'd1, 1'b1, "t5 tick one period later");
        applyStimulus(1'b0, 6'h31, 8'h55);
        step(3);
        checkOutput(KIND_DOUT_A, 6'h30, 8'd0, 1'b1, "t5 prescaler restarted");
        checkOutput(KIND_DOUT_A, 6'h30, 8'd1, 1'b1, "t5 tick after restart");

        // 5b: STATUS clear colliding with a MATCH set on dut_a ch1
        $display("[TB] status clear collision");
        applyStimulus(1'b0, 6'h10, 8'h00);
        applyStimulus(1'b0, 6'h19, 8'h01);
        checkOutput(KIND_DOUT_A, 6'h19, 8'h00, 1'b1, "t5 status cleared first");
        step(13);
        applyStimulus(1'b0, 6'h19, 8'h01);
        checkOutput(KIND_DOUT_A, 6'h19, 8'h01, 1'b1, "t5 match wins over clear");
        checkOutput(KIND_INT_A,  6'h00, 8'h00, 1'b0, "t5 int_n low");

        // 6: asynchronous reset mid-operation
        $display("[TB] async reset");
        reset_n = 1'b0;
        checkOutput(KIND_INT_A,  6'h00, 8'h01, 1'b0, "t6 int_n a released by reset");
        checkOutput(KIND_INT_B,  6'h00, 8'h01, 1'b0, "t6 int_n b released by reset");
        checkOutput(KIND_DOUT_A, 6'h19, 8'h00, 1'b1, "t6 ch1 status reset");
        checkOutput(KIND_DOUT_A, 6'h18, 8'h00, 1'b1, "t6 ch1 ctrl reset");
        checkOutput(KIND_DOUT_A, 6'h14, 8'h00, 1'b1, "t6 ch1 compare reset");
        checkOutput(KIND_DOUT_A, 6'h08, 8'h01, 1'b1, "t6 ch0 ctrl reset");
        checkOutput(KIND_DOUT_A, 6'h00, 8'h00, 1'b1, "t6 ch0 count reset");
        checkOutput(KIND_DOUT_B, 6'h29, 8'h00, 1'b1, "t6 dut_b status reset");
        reset_n = 1'b1;

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
